// File: rtl/button_events_pkg.sv
// ---------------------------------------------------------------------------
// button_events_pkg
// Shared types and sizing helpers for the pushbutton event decoder.
//   state_t       : gesture FSM states
//   timer_width() : width of the saturating gesture timer
//   count_width() : width of a counter that must reach (cycles - 1)
// ---------------------------------------------------------------------------
package button_events_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESSED      = 2'd1,
    WAIT_GAP     = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  // Wide enough to hold the larger of the two gesture durations.
  function automatic int timer_width(input int long_cycles, input int gap_cycles);
    int max_v;
    max_v = (long_cycles > gap_cycles) ? long_cycles : gap_cycles;
    return $clog2(max_v + 1);
  endfunction

  // Wide enough to count 0 .. cycles-1 (never narrower than one bit).
  function automatic int count_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Synchronises the raw pad and filters contact bounce.
//   clock, reset : system clock, async active-high reset
//   btn          : raw asynchronous pad level
//   level        : debounced level, 1 = pressed (registered)
//   rise, fall   : single-cycle strobes, high in the cycle *before* level
//                  changes, so a consumer clocked on the same edge moves in
//                  step with level
// A raw edge that stays stable shows up on level 2 + DEBOUNCE_CYCLES cycles
// later (2 synchroniser flops, then DEBOUNCE_CYCLES agreeing cycles).
// ---------------------------------------------------------------------------
module button_debounce
  import button_events_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W        = count_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Raw pad value that means "released"; the synchroniser resets to it so a
  // button held through reset is seen as a fresh press afterwards.
  localparam logic             RELEASED_RAW = ACTIVE_LOW;

  logic             sync1_r;
  logic             sync2_r;
  logic             pressed_s;
  logic             differ_s;
  logic             toggle_s;
  logic             level_r;
  logic [CNT_W-1:0] cnt_r;

  // Two-flop synchroniser on the asynchronous pad.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= RELEASED_RAW;
      sync2_r <= RELEASED_RAW;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  assign pressed_s = ACTIVE_LOW ? ~sync2_r : sync2_r;
  assign differ_s  = (pressed_s != level_r);
  // Counter has already seen DEBOUNCE_CYCLES-1 disagreeing cycles and the
  // input still disagrees: this is the last one, flip on this edge.
  assign toggle_s  = differ_s && (cnt_r == CNT_LAST);

  // Stability counter and debounced level; any agreeing cycle restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r   <= CNT_W'(0);
      level_r <= 1'b0;
    end else if (toggle_s) begin
      cnt_r   <= CNT_W'(0);
      level_r <= ~level_r;
    end else if (differ_s) begin
      cnt_r   <= cnt_r + CNT_W'(1);
      level_r <= level_r;
    end else begin
      cnt_r   <= CNT_W'(0);
      level_r <= level_r;
    end
  end

  assign level = level_r;
  assign rise  = toggle_s & ~level_r;
  assign fall  = toggle_s &  level_r;

endmodule

// File: rtl/button_events.sv
// ---------------------------------------------------------------------------
// button_events
// Debounced pushbutton decoded into short / long / double press pulses.
//   clock     : system clock (48 MHz HFOSC)
//   reset     : asynchronous reset, active-high
//   io_btn    : raw asynchronous button pad
//   io_level  : debounced level, 1 = pressed
//   io_short  : one-cycle pulse, GAP_CYCLES cycles after the release of a
//               press shorter than LONG_CYCLES with no second press
//   io_long   : one-cycle pulse, LONG_CYCLES cycles after io_level rises
//   io_double : one-cycle pulse, the cycle after the second io_level rise
// The timer counts cycles spent in the current state (0 on the first cycle),
// so io_level held for exactly LONG_CYCLES cycles is a long press and one
// cycle less is a short press.
// ---------------------------------------------------------------------------
module button_events
  import button_events_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int LONG_CYCLES     = 48000000,
  parameter int GAP_CYCLES      = 14400000
) (
  input  logic clock,
  input  logic reset,
  input  logic io_btn,
  output logic io_level,
  output logic io_short,
  output logic io_long,
  output logic io_double
);

  localparam int                 TIMER_W   = timer_width(LONG_CYCLES, GAP_CYCLES);
  localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(LONG_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = {TIMER_W{1'b1}};

  logic               level_s;
  logic               rise_s;
  logic               fall_s;
  state_t             state_r;
  state_t             state_nxt_s;
  logic [TIMER_W-1:0] timer_r;
  logic               long_hit_s;
  logic               gap_hit_s;
  logic               short_s;
  logic               long_s;
  logic               dbl_s;
  logic               dbl_hit_r;

  button_debounce #(
    .ACTIVE_LOW      (ACTIVE_LOW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock (clock),
    .reset (reset),
    .btn   (io_btn),
    .level (level_s),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  assign io_level   = level_s;
  // Expiry is flagged on the last cycle so the registered pulse lands exactly
  // LONG_CYCLES / GAP_CYCLES cycles after the level edge.
  assign long_hit_s = (timer_r == LONG_LAST);
  assign gap_hit_s  = (timer_r == GAP_LAST);

  // Gesture state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; expiry outranks a same-cycle fall, a rise outranks gap expiry.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (rise_s) state_nxt_s = PRESSED;
        else        state_nxt_s = IDLE;
      end
      PRESSED: begin
        if (long_hit_s)  state_nxt_s = WAIT_RELEASE;
        else if (fall_s) state_nxt_s = WAIT_GAP;
        else             state_nxt_s = PRESSED;
      end
      WAIT_GAP: begin
        if (rise_s)         state_nxt_s = WAIT_RELEASE;
        else if (gap_hit_s) state_nxt_s = IDLE;
        else                state_nxt_s = WAIT_GAP;
      end
      WAIT_RELEASE: begin
        // !level_s covers a release that coincided with long expiry: the fall
        // strobe has already gone by, so leave on the first low cycle.
        if (fall_s || !level_s) state_nxt_s = IDLE;
        else                    state_nxt_s = WAIT_RELEASE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Event decode; only one of the three can be set, by construction of the states.
  always_comb begin
    short_s = 1'b0;
    long_s  = 1'b0;
    dbl_s   = 1'b0;
    case (state_r)
      PRESSED: begin
        long_s = long_hit_s;
      end
      WAIT_GAP: begin
        dbl_s   = rise_s;
        short_s = gap_hit_s & ~rise_s;
      end
      default: begin
        short_s = 1'b0;
        long_s  = 1'b0;
        dbl_s   = 1'b0;
      end
    endcase
  end

  // Saturating gesture timer, restarted on every state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_r <= TIMER_W'(0);
    end else if (state_nxt_s != state_r) begin
      timer_r <= TIMER_W'(0);
    end else if (timer_r != TIMER_MAX) begin
      timer_r <= timer_r + TIMER_W'(1);
    end else begin
      timer_r <= timer_r;
    end
  end

  // Event pulse registers; double passes through one extra flop so it appears
  // the cycle after io_level shows the second press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_short  <= 1'b0;
      io_long   <= 1'b0;
      dbl_hit_r <= 1'b0;
      io_double <= 1'b0;
    end else begin
      io_short  <= short_s;
      io_long   <= long_s;
      dbl_hit_r <= dbl_s;
      io_double <= dbl_hit_r;
    end
  end

endmodule

// File: tb/tb_button_events.sv
// ---------------------------------------------------------------------------
// tb_button_events
// Directed bench for button_events with DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
// GAP_CYCLES=10, ACTIVE_LOW=1. Cycle 0 of each scenario is the cycle in
// which the first stimulus value is driven; a raw edge driven in cycle c
// shows on io_level in cycle c+6.
// ---------------------------------------------------------------------------
module tb_button_events;

  logic clock;
  logic reset;
  logic io_btn;
  logic io_level;
  logic io_short;
  logic io_long;
  logic io_double;

  int total;
  int bad;

  // per-scenario observation record
  int   cyc;
  int   rise_at, fall_at, short_at, long_at, double_at;
  int   n_rise, n_fall, n_short, n_long, n_double, n_multi;
  logic prev_level;

  button_events #(
    .ACTIVE_LOW      (1'b1),
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (20),
    .GAP_CYCLES      (10)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .io_btn    (io_btn),
    .io_level  (io_level),
    .io_short  (io_short),
    .io_long   (io_long),
    .io_double (io_double)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clear_rec();
    cyc = 0;
    rise_at = -1; fall_at = -1; short_at = -1; long_at = -1; double_at = -1;
    n_rise = 0; n_fall = 0; n_short = 0; n_long = 0; n_double = 0; n_multi = 0;
    prev_level = io_level;
  endtask

  // drive b during the current cycle, advance one clock, record what the DUT shows
  task automatic step(input logic b);
    io_btn = b;
    @(posedge clock);
    #1;
    cyc++;
    if (io_level === 1'b1 && prev_level === 1'b0) begin
      n_rise++;
      if (rise_at < 0) rise_at = cyc;
    end
    if (io_level === 1'b0 && prev_level === 1'b1) begin
      n_fall++;
      if (fall_at < 0) fall_at = cyc;
    end
    prev_level = io_level;
    if (io_short === 1'b1) begin n_short++; if (short_at < 0) short_at = cyc; end
    if (io_long === 1'b1) begin n_long++; if (long_at < 0) long_at = cyc; end
    if (io_double === 1'b1) begin n_double++; if (double_at < 0) double_at = cyc; end
    if ((int'(io_short) + int'(io_long) + int'(io_double)) > 1) n_multi++;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    io_btn = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    total++; if (io_level !== 1'b0) begin bad++; $display("FAIL reset.level got=%b want=0", io_level); end
    total++; if ({io_short, io_long, io_double} !== 3'b000) begin bad++; $display("FAIL reset.events got=%b want=000", {io_short, io_long, io_double}); end
    reset = 1'b0;
    clear_rec();
    for (int i = 0; i < 12; i++) step(1'b1);
    total++; if (n_rise !== 0) begin bad++; $display("FAIL idle.rises got=%0d want=0", n_rise); end
    total++; if (n_short + n_long + n_double !== 0) begin bad++; $display("FAIL idle.events got=%0d want=0", n_short + n_long + n_double); end
  endtask

  task automatic test_bounce();
    clear_rec();
    for (int i = 0; i < 30; i++) step((i < 12) ? (((i / 2) % 2) == 1) : 1'b0);
    total++; if (rise_at !== 18) begin bad++; $display("FAIL bounce.rise_at got=%0d want=18", rise_at); end
    total++; if (n_rise !== 1 || n_fall !== 0) begin bad++; $display("FAIL bounce.glitch got rises=%0d falls=%0d want 1/0", n_rise, n_fall); end
    total++; if (n_short + n_long + n_double !== 0) begin bad++; $display("FAIL bounce.events got=%0d want=0", n_short + n_long + n_double); end
    for (int i = 0; i < 50; i++) step(1'b1);
  endtask

  task automatic test_short();
    clear_rec();
    for (int i = 0; i < 40; i++) step((i < 8) ? 1'b0 : 1'b1);
    total++; if (rise_at !== 6) begin bad++; $display("FAIL short.rise_at got=%0d want=6", rise_at); end
    total++; if (fall_at !== 14) begin bad++; $display("FAIL short.fall_at got=%0d want=14", fall_at); end
    total++; if (short_at !== 24) begin bad++; $display("FAIL short.short_at got=%0d want=24", short_at); end
    total++; if (n_short !== 1) begin bad++; $display("FAIL short.width got=%0d want=1", n_short); end
    total++; if (n_long !== 0 || n_double !== 0) begin bad++; $display("FAIL short.others got long=%0d double=%0d want 0/0", n_long, n_double); end
  endtask

  task automatic test_long();
    clear_rec();
    for (int i = 0; i < 60; i++) step((i < 30) ? 1'b0 : 1'b1);
    total++; if (long_at !== 26) begin bad++; $display("FAIL long.long_at got=%0d want=26", long_at); end
    total++; if (n_long !== 1) begin bad++; $display("FAIL long.width got=%0d want=1", n_long); end
    total++; if (fall_at !== 36) begin bad++; $display("FAIL long.fall_at got=%0d want=36", fall_at); end
    total++; if (n_short !== 0 || n_double !== 0) begin bad++; $display("FAIL long.after_release got short=%0d double=%0d want 0/0", n_short, n_double); end
  endtask

  task automatic test_double();
    clear_rec();
    for (int i = 0; i < 50; i++) step((i < 5 || (i >= 11 && i < 25)) ? 1'b0 : 1'b1);
    total++; if (n_rise !== 2) begin bad++; $display("FAIL double.rises got=%0d want=2", n_rise); end
    total++; if (double_at !== 18) begin bad++; $display("FAIL double.double_at got=%0d want=18", double_at); end
    total++; if (n_double !== 1) begin bad++; $display("FAIL double.width got=%0d want=1", n_double); end
    total++; if (n_short !== 0 || n_long !== 0) begin bad++; $display("FAIL double.others got short=%0d long=%0d want 0/0", n_short, n_long); end
    total++; if (n_multi !== 0) begin bad++; $display("FAIL double.overlap got=%0d want=0", n_multi); end
  endtask

  task automatic test_boundaries();
    // held 19 cycles: short path
    clear_rec();
    for (int i = 0; i < 50; i++) step((i < 19) ? 1'b0 : 1'b1);
    total++; if (fall_at !== 25) begin bad++; $display("FAIL b19.fall_at got=%0d want=25", fall_at); end
    total++; if (short_at !== 35 || n_short !== 1) begin bad++; $display("FAIL b19.short got at=%0d n=%0d want 35/1", short_at, n_short); end
    total++; if (n_long !== 0) begin bad++; $display("FAIL b19.long got=%0d want=0", n_long); end
    // held 20 cycles: release coincides with long expiry
    clear_rec();
    for (int i = 0; i < 50; i++) step((i < 20) ? 1'b0 : 1'b1);
    total++; if (long_at !== 26 || n_long !== 1) begin bad++; $display("FAIL b20.long got at=%0d n=%0d want 26/1", long_at, n_long); end
    total++; if (fall_at !== 26) begin bad++; $display("FAIL b20.fall_at got=%0d want=26", fall_at); end
    total++; if (n_short !== 0 || n_double !== 0) begin bad++; $display("FAIL b20.others got short=%0d double=%0d want 0/0", n_short, n_double); end
    // second rise on the gap-expiry cycle
    clear_rec();
    for (int i = 0; i < 50; i++) step((i < 5 || (i >= 15 && i < 25)) ? 1'b0 : 1'b1);
    total++; if (double_at !== 22 || n_double !== 1) begin bad++; $display("FAIL gapedge.double got at=%0d n=%0d want 22/1", double_at, n_double); end
    total++; if (n_short !== 0 || n_long !== 0) begin bad++; $display("FAIL gapedge.others got short=%0d long=%0d want 0/0", n_short, n_long); end
  endtask

  task automatic test_reset_mid_press();
    clear_rec();
    for (int i = 0; i < 16; i++) step(1'b0);
    total++; if (io_level !== 1'b1) begin bad++; $display("FAIL midrst.level_before got=%b want=1", io_level); end
    reset = 1'b1;
    #1;
    total++; if ({io_level, io_short, io_long, io_double} !== 4'b0000) begin bad++; $display("FAIL midrst.async_clear got=%b want=0000", {io_level, io_short, io_long, io_double}); end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    clear_rec();
    for (int i = 0; i < 40; i++) step(1'b0);
    total++; if (rise_at !== 6) begin bad++; $display("FAIL midrst.rise_at got=%0d want=6", rise_at); end
    total++; if (long_at !== 26 || n_long !== 1) begin bad++; $display("FAIL midrst.long got at=%0d n=%0d want 26/1", long_at, n_long); end
    total++; if (n_short !== 0 || n_double !== 0) begin bad++; $display("FAIL midrst.others got short=%0d double=%0d want 0/0", n_short, n_double); end
    for (int i = 0; i < 30; i++) step(1'b1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_bounce();
    test_short();
    test_long();
    test_double();
    test_boundaries();
    test_reset_mid_press();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
